// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder that sequences one FullAdder cell, LSB first.
// Optional carry-in port enabled by defining SERIAL_ADDER_CIN_EN.
`default_nettype none

module FullAdder (
  input  logic i1,
  input  logic i2,
  input  logic ic,
  output logic sum,
  output logic carry
);
  assign sum   = i1 ^ i2 ^ ic;
  assign carry = (i1 & i2) | (i1 & ic) | (i2 & ic);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry_q;
  logic [CW-1:0]    r_cnt;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum_next;

`ifdef SERIAL_ADDER_CIN_EN
  assign w_cin = cin;
`else
  assign w_cin = 1'b0;
`endif

  FullAdder u_fa (
    .i1    (r_a_sh[0]),
    .i2    (r_b_sh[0]),
    .ic    (r_carry_q),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0].
  generate
    if (WIDTH == 1) begin : g_one_bit
      assign w_sum_next = w_fa_sum;
    end else begin : g_multi_bit
      assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum_sh;
  assign cout      = r_carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_sum_sh  <= '0;
      r_carry_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh    <= a;
            r_b_sh    <= b;
            r_carry_q <= w_cin;
            r_sum_sh  <= '0;
            r_cnt     <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_sum_sh  <= w_sum_next;
          r_carry_q <= w_fa_carry;
          r_cnt     <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder at WIDTH=8.
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_tests;
  int n_fail;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_ADDER_CIN_EN
    .cin       (cin),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one acceptance edge; returns just after that edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL start_ready: in_ready=%b expected 1", in_ready);
    end
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the acceptance edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (lat !== W) begin
      n_fail++;
      $display("FAIL latency: edges_after_accept=%0d expected %0d", lat, W);
    end
  endtask

  task automatic check_result(input string name, input logic [W-1:0] es, input logic ec);
    n_tests++;
    if (sum !== es || cout !== ec) begin
      n_fail++;
      $display("FAIL %s: sum=%h cout=%b expected sum=%h cout=%b", name, sum, cout, es, ec);
    end
  endtask

  // Runs one full operation with out_ready already high; checks result and return to IDLE.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es, input logic ec);
    int lat;
    out_ready = 1'b1;
    start_op(ta, tb, tc);
    wait_done(lat);
    check_result(name, es, ec);
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle: in_ready=%b out_valid=%b expected 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b sum=%h cout=%b expected 1/0/00/0",
               in_ready, out_valid, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("add_a5_5b", 8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1);
    run_op("add_33_0f", 8'h33, 8'h0F, 1'b0, 8'h42, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    out_ready = 1'b0;
    start_op(8'hC3, 8'h7E, 1'b0);
    wait_done(lat);
    check_result("bp_result", 8'h41, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (sum !== 8'h41 || cout !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: sum=%h cout=%b in_ready=%b out_valid=%b expected 41/1/0/1",
                 i, sum, cout, in_ready, out_valid);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_inputs();
    int lat;
    out_ready = 1'b1;
    start_op(8'h21, 8'h43, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 8'hF0 + 8'(i);
      b = 8'h0F ^ 8'(i);
      cin = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    cin = 1'b0;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_ready: in_ready=%b expected 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_result("ignore_result", 8'h64, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    out_ready = 1'b1;
    start_op(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b sum=%h cout=%b expected 1/0/00/0",
               in_ready, out_valid, sum, cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
  endtask

`ifdef SERIAL_ADDER_CIN_EN
  task automatic test_cin();
    run_op("cin_ff_00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("cin_10_20", 8'h10, 8'h20, 1'b1, 8'h31, 1'b0);
  endtask
`else
  task automatic test_cin();
    // Without the carry-in port the cin drive must have no effect.
    run_op("nocin_ff_00", 8'hFF, 8'h00, 1'b1, 8'hFF, 1'b0);
    run_op("nocin_10_20", 8'h10, 8'h20, 1'b1, 8'h30, 1'b0);
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_ignore_inputs();
    test_reset_mid_run();
    test_cin();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
